// File: rtl/cordic_arbiter_if.sv
// Bundles the requester-side and core-side signals of the shared cordic arbiter.
// slave is the arbiter's view; master is the view of the surrounding requesters and core.
interface cordic_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]    REQ_I;
    logic [20*N_REQ-1:0] ANGLE_I;
    logic [N_REQ-1:0]    GNT_O;
    logic [N_REQ-1:0]    VALID_O;
    logic [ID_W-1:0]     RES_ID_O;
    logic signed [31:0]  RES_COS_O;
    logic signed [31:0]  RES_SIN_O;
    logic                ERR_O;
    logic                BUSY_O;
    logic signed [19:0]  CORE_Z0_O;
    logic                CORE_READY_O;
    logic signed [31:0]  CORE_COS_I;
    logic signed [31:0]  CORE_SIN_I;
    logic                CORE_DONE_I;

    modport slave (
        input  REQ_I, ANGLE_I, CORE_COS_I, CORE_SIN_I, CORE_DONE_I,
        output GNT_O, VALID_O, RES_ID_O, RES_COS_O, RES_SIN_O, ERR_O, BUSY_O,
               CORE_Z0_O, CORE_READY_O
    );

    modport master (
        output REQ_I, ANGLE_I, CORE_COS_I, CORE_SIN_I, CORE_DONE_I,
        input  GNT_O, VALID_O, RES_ID_O, RES_COS_O, RES_SIN_O, ERR_O, BUSY_O,
               CORE_Z0_O, CORE_READY_O
    );
endinterface

// File: rtl/cordic_arbiter.sv
// Round-robin share of one iterative cordic core: grant 1 cycle after an IDLE request, VALID 1 cycle after core done edge.
// Requesters hold REQ until GNT; a watchdog aborts a transaction whose core never completes.
module cordic_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 63
) (
    input  logic            CLK_I,
    input  logic            RST_N_I,
    cordic_arbiter_if.slave bus
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_id;
    logic [ID_W-1:0]    r_res_id;
    logic [ID_W-1:0]    w_pick;
    logic signed [19:0] r_angle;
    logic signed [31:0] r_res_cos;
    logic signed [31:0] r_res_sin;
    logic [WD_W-1:0]    r_wd;
    logic [WD_W-1:0]    w_wd_inc;
    logic               r_done_q;
    logic               r_err;
    logic               w_done_rise;
    logic               w_start;
    logic               w_capture;
    logic               w_abort;
    logic [N_REQ-1:0]   w_id_onehot;

    // First requester at or after the pointer, searching upward with wrap.
    function automatic logic [ID_W-1:0] f_pick(input logic [N_REQ-1:0] req,
                                               input logic [ID_W-1:0]  ptr);
        logic [ID_W-1:0]  pick;
        logic [N_REQ-1:0] bit_one;
        int               idx;
        pick    = '0;
        bit_one = {{(N_REQ-1){1'b0}}, 1'b1};
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (|(req & (bit_one << idx))) begin
                pick = idx[ID_W-1:0];
            end
        end
        return pick;
    endfunction

    assign w_pick      = f_pick(bus.REQ_I, r_ptr);
    assign w_done_rise = bus.CORE_DONE_I & ~r_done_q;
    assign w_wd_inc    = r_wd + WD_W'(1);
    assign w_id_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << r_id;

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_capture   = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|bus.REQ_I) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // Only a fresh rising edge counts; a level left over from the last job is ignored.
                if (w_done_rise) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_RESP;
                end else if (w_wd_inc == WD_W'(TIMEOUT)) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            r_ptr     <= '0;
            r_id      <= '0;
            r_res_id  <= '0;
            r_angle   <= '0;
            r_res_cos <= '0;
            r_res_sin <= '0;
            r_wd      <= '0;
            r_done_q  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done_q <= bus.CORE_DONE_I;
            r_err    <= w_abort;
            if (w_start) begin
                r_id    <= w_pick;
                r_angle <= bus.ANGLE_I[int'(w_pick)*20 +: 20];
            end
            if (r_state == S_ISSUE) begin
                r_wd  <= '0;
                r_ptr <= (r_id == ID_W'(N_REQ - 1)) ? '0 : r_id + ID_W'(1);
            end else if (r_state == S_WAIT) begin
                r_wd <= w_wd_inc;
            end
            if (w_capture) begin
                r_res_cos <= bus.CORE_COS_I;
                r_res_sin <= bus.CORE_SIN_I;
                r_res_id  <= r_id;
            end else if (w_abort) begin
                r_res_id <= r_id;
            end
        end
    end

    assign bus.GNT_O        = (r_state == S_ISSUE) ? w_id_onehot : '0;
    assign bus.VALID_O      = (r_state == S_RESP)  ? w_id_onehot : '0;
    assign bus.CORE_READY_O = (r_state == S_ISSUE);
    assign bus.BUSY_O       = (r_state != S_IDLE);
    assign bus.ERR_O        = r_err;
    assign bus.CORE_Z0_O    = r_angle;
    assign bus.RES_ID_O     = r_res_id;
    assign bus.RES_COS_O    = r_res_cos;
    assign bus.RES_SIN_O    = r_res_sin;
endmodule

// File: doc/cordic_arbiter.md
Name: cordic_arbiter

Overview:
- Shares one iterative cordic core among N_REQ independent requesters.
- Arbitration is round-robin.
- The block sequences each core transaction: start pulse, then wait for completion, then capture the result.
- The result is returned to the winning requester with a requester ID.
- Sits between the angle-producing front-end blocks and the single cordic instance.
- A watchdog recovers the arbiter if the core never completes.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester ID; must satisfy 2**ID_W >= N_REQ.
- TIMEOUT, 63, maximum WAIT cycles before aborting a transaction.

Ports:
- CLK_I  in  1  clock.
- RST_N_I  in  1  reset.
- REQ_I  in  N_REQ  per-requester request; held high until the matching GNT_O.
- ANGLE_I  in  20*N_REQ  signed angles; requester k occupies bits [20k+19:20k].
- GNT_O  out  N_REQ  one-cycle accept pulse, one-hot.
- VALID_O  out  N_REQ  one-cycle result-valid pulse, one-hot.
- RES_ID_O  out  ID_W  ID of the last completed transaction.
- RES_COS_O  out  32  signed cosine result.
- RES_SIN_O  out  32  signed sine result.
- ERR_O  out  1  one-cycle pulse on watchdog abort.
- BUSY_O  out  1  high in any state other than IDLE.
- CORE_Z0_O  out  20  angle driven to the core.
- CORE_READY_O  out  1  core start pulse.
- CORE_COS_I  in  32  core cosine output.
- CORE_SIN_I  in  32  core sine output.
- CORE_DONE_I  in  1  core done level. The core clears it on start and sets it on completion.

Behaviour:
- Clock and reset: one clock, CLK_I. RST_N_I is the reset: asynchronous, active-low.
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Round-robin pointer 0, so requester 0 has highest priority.
  - Internal done_q = 0.
  - Watchdog counter 0.
- Reset mid-operation: the transaction is dropped and no VALID_O or ERR_O is issued. The requester re-requests after reset.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If REQ_I != 0, choose the winner: the first set bit at or after the pointer, searching upward with wrap.
  - Latch the winner's ID and ANGLE_I slice, then go to ISSUE.
  - If no requests, stay in IDLE.
- ISSUE, exactly one cycle:
  - GNT_O[id]=1 and CORE_READY_O=1.
  - Pointer becomes (id+1) mod N_REQ.
  - Watchdog cleared. Next state WAIT.
- WAIT:
  - CORE_Z0_O keeps the latched angle stable from ISSUE through WAIT.
  - done_q registers CORE_DONE_I every cycle in all states.
  - Completion is the rising edge only: CORE_DONE_I & ~done_q. A stale high DONE from the previous transaction is never accepted.
  - On edge: capture CORE_COS_I/CORE_SIN_I into RES_COS_O/RES_SIN_O and set RES_ID_O=id. Go to RESP.
  - Else watchdog++. When watchdog == TIMEOUT: ERR_O=1 for one cycle, RES_ID_O=id, results unchanged, no VALID_O, go to IDLE.
- RESP, one cycle: VALID_O[id]=1, then go to IDLE.
- RES_* hold their value until the next capture.
- Latency:
  - REQ_I high in IDLE at edge k gives GNT_O high in cycle k+1.
  - With the production cordic core (19 iterations), VALID_O is high exactly 21 cycles after the GNT_O cycle.
  - Back-to-back throughput: one transaction per 23 cycles.
- Simultaneous requests: exactly one grant per transaction; never more than one bit of GNT_O or VALID_O set.
- Requests arriving outside IDLE are held by the requester and serviced in round-robin order.
- A requester that drops REQ_I before its grant is skipped; no fairness credit is kept.
- Pointer wraps from N_REQ-1 to 0.
- Width rules: the angle passes unmodified (20-bit signed). The 32-bit results pass unmodified, with no rounding or saturation.
- CORE_READY_O is never asserted outside ISSUE.

Test Plan:
- Single request: REQ_I=0001 with angle 0 → GNT_O=0001 one cycle later. VALID_O=0001 21 cycles after GNT, RES_ID_O=0, RES_COS_O≈262144 (±16), RES_SIN_O≈0 (±16).
- All four requesting: angles {0, 205887, -205887, 102944} → grants in order 0,1,2,3. Each gets its own VALID with matching RES_ID_O. For IDs 1 and 2, sin ≈ ±185364 and cos ≈ 185364.
- Fairness: requesters 0 and 2 held high for 6 transactions → grant sequence 0,2,0,2,0,2. Requester 0 is never granted twice consecutively.
- Stale DONE: CORE_DONE_I held high through ISSUE and the first WAIT cycles (core model delays its clear) → no capture until a fresh rising edge.
- Watchdog: core model never raises DONE → ERR_O pulses at WAIT cycle 63 with RES_ID_O=id and no VALID_O. The next request is serviced normally.
- Reset mid-WAIT: RST_N_I low in cycle 10 after grant → all outputs 0 immediately. After release, a new REQ_I=0100 is granted in 1 cycle and pointer priority starts at 0.
